// File: rtl/clic_irq_delivery.sv
// rtl/clic_irq_delivery.sv - CLIC core-side interrupt delivery stage
//
// Latches the winning arbitration candidate and presents it to the core. The
// payload is held stable until the core accepts it or a kill handshake
// withdraws it. Acceptance produces a one-cycle claim pulse for the gateway.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   cand_*_i                 arbitration winner (valid, id, level, priv, shv)
//   irq_valid_o/irq_ready_i  presentation handshake to the core
//   irq_id_o .. irq_shv_o    presented payload, frozen while irq_valid_o=1
//   irq_kill_req_o           request to withdraw the presented interrupt
//   irq_kill_ack_i           core confirms the withdrawal
//   claim_valid_o            one-cycle pulse on acceptance
//   claim_id_o               id of the last accepted interrupt (held)

module clic_irq_delivery #(
    parameter int N_SOURCE   = 256,
    parameter int SRC_W      = $clog2(N_SOURCE),
    parameter int INTCTLBITS = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cand_valid_i,
    input  logic [SRC_W-1:0]      cand_id_i,
    input  logic [INTCTLBITS-1:0] cand_level_i,
    input  logic [1:0]            cand_priv_i,
    input  logic                  cand_shv_i,
    output logic                  irq_valid_o,
    input  logic                  irq_ready_i,
    output logic [SRC_W-1:0]      irq_id_o,
    output logic [INTCTLBITS-1:0] irq_level_o,
    output logic [1:0]            irq_priv_o,
    output logic                  irq_shv_o,
    output logic                  irq_kill_req_o,
    input  logic                  irq_kill_ack_i,
    output logic                  claim_valid_o,
    output logic [SRC_W-1:0]      claim_id_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        KILL = 2'd2
    } state_t;

    state_t state;
    logic   same;

    // The presented payload registers double as the latched copy, so the
    // comparison is always against exactly what the core sees.
    assign same = cand_valid_i
               && (cand_id_i    == irq_id_o)
               && (cand_level_i == irq_level_o)
               && (cand_priv_i  == irq_priv_o)
               && (cand_shv_i   == irq_shv_o);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= IDLE;
            irq_valid_o    <= 1'b0;
            irq_id_o       <= '0;
            irq_level_o    <= '0;
            irq_priv_o     <= '0;
            irq_shv_o      <= 1'b0;
            irq_kill_req_o <= 1'b0;
            claim_valid_o  <= 1'b0;
            claim_id_o     <= '0;
        end else begin
            // Claim is a single-cycle pulse; only an acceptance re-arms it,
            // and acceptance always leaves through IDLE, so it can never
            // be high on two consecutive cycles.
            claim_valid_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (cand_valid_i) begin
                        state       <= REQ;
                        irq_valid_o <= 1'b1;
                        irq_id_o    <= cand_id_i;
                        irq_level_o <= cand_level_i;
                        irq_priv_o  <= cand_priv_i;
                        irq_shv_o   <= cand_shv_i;
                    end
                end

                REQ: begin
                    if (irq_ready_i) begin
                        state         <= IDLE;
                        irq_valid_o   <= 1'b0;
                        claim_valid_o <= 1'b1;
                        claim_id_o    <= irq_id_o;
                    end else if (!same) begin
                        // Winner changed or vanished: keep presenting the old
                        // payload and ask the core to let go of it.
                        state          <= KILL;
                        irq_kill_req_o <= 1'b1;
                    end
                end

                KILL: begin
                    // A core that accepts in the same cycle it acks the kill
                    // has already taken the interrupt, so acceptance wins.
                    if (irq_ready_i) begin
                        state          <= IDLE;
                        irq_valid_o    <= 1'b0;
                        irq_kill_req_o <= 1'b0;
                        claim_valid_o  <= 1'b1;
                        claim_id_o     <= irq_id_o;
                    end else if (irq_kill_ack_i) begin
                        state          <= IDLE;
                        irq_valid_o    <= 1'b0;
                        irq_kill_req_o <= 1'b0;
                    end
                end

                default: begin
                    state          <= IDLE;
                    irq_valid_o    <= 1'b0;
                    irq_kill_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clic_irq_delivery.sv
// tb/tb_clic_irq_delivery.sv - self-checking bench for clic_irq_delivery

module tb_clic_irq_delivery;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       cand_valid_i;
    logic [7:0] cand_id_i;
    logic [7:0] cand_level_i;
    logic [1:0] cand_priv_i;
    logic       cand_shv_i;
    logic       irq_valid_o;
    logic       irq_ready_i;
    logic [7:0] irq_id_o;
    logic [7:0] irq_level_o;
    logic [1:0] irq_priv_o;
    logic       irq_shv_o;
    logic       irq_kill_req_o;
    logic       irq_kill_ack_i;
    logic       claim_valid_o;
    logic [7:0] claim_id_o;

    int checks = 0;
    int errors = 0;

    // Reference model: a presented transaction plus a "being withdrawn" flag.
    logic [18:0] m_pay;
    logic        m_presenting;
    logic        m_withdrawing;
    logic        m_claim;
    logic [7:0]  m_claim_id;

    always #5 clk_i = ~clk_i;

    clic_irq_delivery #(.N_SOURCE(256), .SRC_W(8), .INTCTLBITS(8)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .cand_valid_i   (cand_valid_i),
        .cand_id_i      (cand_id_i),
        .cand_level_i   (cand_level_i),
        .cand_priv_i    (cand_priv_i),
        .cand_shv_i     (cand_shv_i),
        .irq_valid_o    (irq_valid_o),
        .irq_ready_i    (irq_ready_i),
        .irq_id_o       (irq_id_o),
        .irq_level_o    (irq_level_o),
        .irq_priv_o     (irq_priv_o),
        .irq_shv_o      (irq_shv_o),
        .irq_kill_req_o (irq_kill_req_o),
        .irq_kill_ack_i (irq_kill_ack_i),
        .claim_valid_o  (claim_valid_o),
        .claim_id_o     (claim_id_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pay         = '0;
        m_presenting  = 1'b0;
        m_withdrawing = 1'b0;
        m_claim       = 1'b0;
        m_claim_id    = '0;
    endtask

    // One clock of the delivery protocol, decided from the rules:
    // accepted beats withdrawn; a presented interrupt whose winner no longer
    // matches starts being withdrawn; nothing is picked up while presenting.
    task automatic model_step();
        logic [18:0] cand;
        logic        accepted, withdrawn;
        cand = {cand_id_i, cand_level_i, cand_priv_i, cand_shv_i};
        m_claim = 1'b0;
        if (!m_presenting) begin
            if (cand_valid_i) begin
                m_pay        = cand;
                m_presenting = 1'b1;
            end
        end else begin
            accepted  = irq_ready_i;
            withdrawn = !accepted && m_withdrawing && irq_kill_ack_i;
            if (accepted) begin
                m_claim    = 1'b1;
                m_claim_id = m_pay[18:11];
            end
            if (accepted || withdrawn) begin
                m_presenting  = 1'b0;
                m_withdrawing = 1'b0;
            end else if (!(cand_valid_i && cand == m_pay)) begin
                m_withdrawing = 1'b1;
            end
        end
    endtask

    task automatic compare_all(input string where);
        check({where, ".valid"}, 32'(irq_valid_o), 32'(m_presenting));
        check({where, ".kill"}, 32'(irq_kill_req_o), 32'(m_withdrawing));
        check({where, ".claim"}, 32'(claim_valid_o), 32'(m_claim));
        check({where, ".claim_id"}, 32'(claim_id_o), 32'(m_claim_id));
        if (m_presenting) begin
            check({where, ".payload"}, 32'({irq_id_o, irq_level_o, irq_priv_o, irq_shv_o}),
                  32'(m_pay));
        end
    endtask

    task automatic step(input string where);
        @(posedge clk_i);
        if (!rst_ni) model_reset();
        else model_step();
        #1;
        compare_all(where);
    endtask

    task automatic set_cand(input logic v, input logic [7:0] id, input logic [7:0] lvl,
                            input logic [1:0] priv, input logic shv);
        cand_valid_i = v;
        cand_id_i    = id;
        cand_level_i = lvl;
        cand_priv_i  = priv;
        cand_shv_i   = shv;
    endtask

    task automatic set_core(input logic ready, input logic ack);
        irq_ready_i    = ready;
        irq_kill_ack_i = ack;
    endtask

    initial begin
        logic [18:0] pool [4];
        logic [18:0] pick;

        // Reset with a candidate already waiting.
        rst_ni = 1'b0;
        set_cand(1'b1, 8'h11, 8'h40, 2'd1, 1'b0);
        set_core(1'b0, 1'b0);
        model_reset();
        step("rst");
        step("rst");
        check("rst.id_zero", 32'(irq_id_o), 32'h0);
        #2 rst_ni = 1'b1;
        step("rst_release");
        check("rst_release.valid_up", 32'(irq_valid_o), 32'h1);
        set_core(1'b1, 1'b0);
        step("rst_accept");
        set_core(1'b0, 1'b0);
        set_cand(1'b0, 8'h0, 8'h0, 2'd0, 1'b0);
        step("rst_idle");

        // Basic accept, ready three cycles after valid.
        set_cand(1'b1, 8'h2A, 8'h80, 2'd3, 1'b1);
        step("basic_valid");
        step("basic_hold1");
        step("basic_hold2");
        set_core(1'b1, 1'b0);
        step("basic_accept");
        check("basic.claim_id", 32'(claim_id_o), 32'h2A);
        set_core(1'b0, 1'b0);
        set_cand(1'b0, 8'h0, 8'h0, 2'd0, 1'b0);
        step("basic_drop");
        check("basic.claim_once", 32'(claim_valid_o), 32'h0);

        // Preemption kill, ack after two cycles, new winner after a bubble.
        set_cand(1'b1, 8'd5, 8'h10, 2'd0, 1'b0);
        step("pre_valid");
        set_cand(1'b1, 8'd9, 8'hFF, 2'd0, 1'b0);
        step("pre_kill");
        check("pre.kill_up", 32'(irq_kill_req_o), 32'h1);
        check("pre.old_id", 32'(irq_id_o), 32'd5);
        step("pre_wait");
        set_core(1'b0, 1'b1);
        step("pre_ack");
        set_core(1'b0, 1'b0);
        check("pre.no_claim", 32'(claim_valid_o), 32'h0);
        step("pre_bubble");
        check("pre.new_id", 32'(irq_id_o), 32'd9);
        set_core(1'b1, 1'b0);
        step("pre_accept9");
        set_core(1'b0, 1'b0);
        set_cand(1'b0, 8'h0, 8'h0, 2'd0, 1'b0);
        step("pre_idle");

        // Ready and kill-ack together in KILL: acceptance wins.
        set_cand(1'b1, 8'd7, 8'h20, 2'd2, 1'b0);
        step("rw_valid");
        set_cand(1'b1, 8'd8, 8'h30, 2'd2, 1'b0);
        step("rw_kill");
        set_core(1'b1, 1'b1);
        step("rw_both");
        check("rw.claim_id", 32'(claim_id_o), 32'd7);
        set_core(1'b0, 1'b0);
        set_cand(1'b0, 8'h0, 8'h0, 2'd0, 1'b0);
        step("rw_idle");

        // Candidate vanishes, then ready during KILL accepts it.
        set_cand(1'b1, 8'd200, 8'h55, 2'd1, 1'b1);
        step("van_valid");
        set_cand(1'b0, 8'd200, 8'h55, 2'd1, 1'b1);
        step("van_kill");
        set_core(1'b1, 1'b0);
        step("van_accept");
        check("van.claim_id", 32'(claim_id_o), 32'd200);
        set_core(1'b0, 1'b0);
        step("van_idle");

        // Asynchronous reset between edges while in KILL.
        set_cand(1'b1, 8'd50, 8'h01, 2'd0, 1'b0);
        step("ar_valid");
        set_cand(1'b1, 8'd51, 8'h01, 2'd0, 1'b0);
        step("ar_kill");
        #2 rst_ni = 1'b0;
        #1;
        model_reset();
        compare_all("ar_async");
        set_cand(1'b0, 8'h0, 8'h0, 2'd0, 1'b0);
        #2 rst_ni = 1'b1;
        step("ar_after1");
        step("ar_after2");

        // Randomized traffic from a small payload pool so matches are common.
        for (int i = 0; i < 4; i++) pool[i] = 19'($urandom);
        pick = pool[0];
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 4) == 0) pick = pool[$urandom_range(0, 3)];
            cand_valid_i   = ($urandom_range(0, 9) < 8);
            {cand_id_i, cand_level_i, cand_priv_i, cand_shv_i} = pick;
            irq_ready_i    = ($urandom_range(0, 3) == 0);
            irq_kill_ack_i = ($urandom_range(0, 2) == 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
